// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and constants for the word-to-bit-serial pattern detection scheduler.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_PAT_W  = 3;

  // Wide enough to hold every count from 0 to word_w inclusive.
  function automatic int cnt_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_pattern_match_fsm.sv
// Bit-serial matcher: keeps the last PAT_W-1 bits and flags when they, together
// with the incoming bit, form the pattern.
module pattern_match_fsm #(
  parameter int PAT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  generate
    if (PAT_W == 1) begin : g_single
      // A one-bit pattern needs no history: every equal bit is a match.
      assign match = bit_valid && (bit_in == pattern[0]);
    end else begin : g_multi
      localparam int SEEN_W = $clog2(PAT_W);
      localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_W - 1);

      logic [PAT_W-2:0] hist;
      logic [SEEN_W-1:0] seen;
      logic [PAT_W-1:0] window;

      assign window = {hist, bit_in};
      // seen saturates, so "full" means at least PAT_W-1 bits already shifted in.
      assign match  = bit_valid && (seen == SEEN_FULL) && (window == pattern);

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would make hist and seen race.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hist <= '0;
          seen <= '0;
        end else if (clear) begin
          hist <= '0;
          seen <= '0;
        end else if (bit_valid) begin
          hist <= window[PAT_W-2:0];
          if (seen != SEEN_FULL) seen <= seen + SEEN_W'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/seq_detect_scheduler.sv
// Accepts a word, streams it MSB-first through the pattern matcher, then
// presents the overlapping-match count and end-position mask.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int WORD_W = DEF_WORD_W,
  parameter  int PAT_W  = DEF_PAT_W,
  localparam int CNT_W  = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PAT_W-1:0]  pattern,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_count,
  output logic [WORD_W-1:0] match_mask
);

  localparam int BIDX_W = $clog2(WORD_W);
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_REPORT = REPORT;

  logic [1:0]        state;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-1:0]  pat_q;
  logic [BIDX_W-1:0] bit_idx;
  logic              accept;
  logic              match;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_REPORT);
  assign accept    = in_ready && in_valid;

  pattern_match_fsm #(.PAT_W(PAT_W)) u_match (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .bit_valid (state == ST_SHIFT),
    .bit_in    (word_q[bit_idx]),
    .pattern   (pat_q),
    .match     (match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      word_q      <= '0;
      pat_q       <= '0;
      bit_idx     <= '0;
      match_count <= '0;
      match_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Word and pattern are latched so producer changes during the scan are harmless.
            word_q      <= in_word;
            pat_q       <= pattern;
            bit_idx     <= BIDX_W'(WORD_W - 1);
            match_count <= '0;
            match_mask  <= '0;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (match) begin
            match_count         <= match_count + CNT_W'(1);
            match_mask[bit_idx] <= 1'b1;
          end
          if (bit_idx == '0) state <= ST_REPORT;
          else               bit_idx <= bit_idx - BIDX_W'(1);
        end
        ST_REPORT: begin
          // Results remain on the outputs after the handshake until the next accept.
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench: a driver pushes model results on accept, a monitor pops on
// each output handshake; directed reset, back-pressure and latency checks too.
module tb_seq_detect_scheduler;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 3;
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int BOUND  = 200;

  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] mask;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_word = '0;
  logic [PAT_W-1:0]  pattern = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  match_count;
  logic [WORD_W-1:0] match_mask;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   sink_mode = 0;  // 0 random, 1 hold low, 2 force high
  exp_t exp_q[$];

  seq_detect_scheduler #(.WORD_W(WORD_W), .PAT_W(PAT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .pattern     (pattern),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .match_count (match_count),
    .match_mask  (match_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Slide a PAT_W window over the word; a window ending at bit j sets mask[j].
  function automatic exp_t model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p);
    exp_t e;
    logic [WORD_W-1:0] sh;
    e.count = '0;
    e.mask  = '0;
    for (int j = 0; j <= WORD_W - PAT_W; j++) begin
      sh = w >> j;
      if (sh[PAT_W-1:0] == p) begin
        e.mask[j] = 1'b1;
        e.count   = e.count + CNT_W'(1);
      end
    end
    return e;
  endfunction

  // Output sink: back-pressure pattern changes just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("match_count", int'(match_count), int'(e.count));
        check("match_mask", int'(match_mask), int'(e.mask));
      end
    end
  end

  // Called from just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p);
    int waited;
    in_valid = 1'b1;
    in_word  = w;
    pattern  = p;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > BOUND) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(w, p));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = WORD_W'($urandom);
    pattern  = PAT_W'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < BOUND) begin
      @(posedge clk);
      waited++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t ea;
    int   cyc;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_mask", int'(match_mask), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed words.
    send(8'b0111_1100, 3'b111);
    send(8'hFF, 3'b111);
    send(8'h00, 3'b111);
    send(8'b1010_1010, 3'b101);
    drain();

    // Back-pressure, latency and ignored in_valid during REPORT.
    sink_mode = 1;
    @(posedge clk);
    #1;
    ea = model(8'b1101_1011, 3'b011);
    send(8'b1101_1011, 3'b011);
    cyc = 0;
    while (cyc < BOUND) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    check("latency_edges", cyc, WORD_W);
    in_valid = 1'b1;
    in_word  = 8'b1110_0111;
    pattern  = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_count_stable", int'(match_count), int'(ea.count));
      check("bp_mask_stable", int'(match_mask), int'(ea.mask));
    end
    sink_mode = 2;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) break;
      cyc++;
      if (cyc > BOUND) begin
        check("bp_release_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);
    check("hold_count_after_hs", int'(match_count), int'(ea.count));
    exp_q.push_back(model(8'b1110_0111, 3'b110));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sink_mode = 0;
    drain();

    // Reset three cycles into a scan discards the word.
    send(8'hA5, 3'b010);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_count", int'(match_count), 0);
    check("midrst_mask", int'(match_mask), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send(8'h0F, 3'b000);
    drain();

    // Random words with random back-pressure; send() scrambles inputs after each accept.
    for (int i = 0; i < 150; i++) begin
      send(WORD_W'($urandom), PAT_W'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
